bram_sdp_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the 2x18 simple-dual-port BRAM mapping. It turns a push/pop FIFO interface into BRAM write-port and read-port address and enable strobes, and consumes the BRAM read data. The controller holds the pointers, the occupancy count and all status flags. The BRAM stores the payload.

---
 rtl/bram_sdp_fifo_ctrl.sv | 150 +++++++++++++++
 tb/tb_bram_sdp_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_fifo_ctrl.sv
// FIFO controller driving a simple-dual-port BRAM: pointers, occupancy, status flags.
// Optional sticky overflow/underflow flags are enabled by defining BRAM_FIFO_ERR_FLAGS_EN.
module bram_sdp_fifo_ctrl #(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH-4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  CLR_i,
  input  logic                  PUSH_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  POP_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  output logic                  FULL_o,
  output logic                  EMPTY_o,
  output logic                  ALMOST_FULL_o,
  output logic                  ALMOST_EMPTY_o,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic [ADDR_WIDTH-1:0] BRAM_WADDR_o,
  output logic [DATA_WIDTH-1:0] BRAM_WDATA_o,
  output logic                  BRAM_WEN_o,
  output logic [1:0]            BRAM_BE_o,
  output logic [ADDR_WIDTH-1:0] BRAM_RADDR_o,
  output logic                  BRAM_REN_o,
  input  logic [DATA_WIDTH-1:0] BRAM_RDATA_i
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  ,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o
`endif
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  // Elaboration-time parameter legality.
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_afull_illegal
    $error("bram_sdp_fifo_ctrl: AFULL_THRESH out of range 0..2**ADDR_WIDTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_aempty_illegal
    $error("bram_sdp_fifo_ctrl: AEMPTY_THRESH out of range 0..2**ADDR_WIDTH");
  end
  if (!(DATA_WIDTH == 1 || DATA_WIDTH == 2 || DATA_WIDTH == 4 || DATA_WIDTH == 8 ||
        DATA_WIDTH == 9 || DATA_WIDTH == 16 || DATA_WIDTH == 18)) begin : g_width_illegal
    $error("bram_sdp_fifo_ctrl: DATA_WIDTH not a legal BRAM port width");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  rvalid_q;
  logic                  push_acc, pop_acc;

  // Flags are registered, so acceptance only looks at last-edge state.
  assign push_acc = PUSH_i & ~full_q  & ~CLR_i;
  assign pop_acc  = POP_i  & ~empty_q & ~CLR_i;

  assign BRAM_WEN_o   = push_acc;
  assign BRAM_BE_o    = {2{push_acc}};
  assign BRAM_WADDR_o = wr_ptr_q;
  assign BRAM_WDATA_o = WDATA_i;
  assign BRAM_REN_o   = pop_acc;
  assign BRAM_RADDR_o = rd_ptr_q;

  assign RDATA_o        = BRAM_RDATA_i;
  assign RVALID_o       = rvalid_q;
  assign COUNT_o        = count_q;
  assign FULL_o         = full_q;
  assign EMPTY_o        = empty_q;
  assign ALMOST_FULL_o  = afull_q;
  assign ALMOST_EMPTY_o = aempty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (CLR_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      rvalid_q <= pop_acc;
    end
  end

`ifdef BRAM_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  assign OVERFLOW_o  = ovf_q;
  assign UNDERFLOW_o = unf_q;

  // Sticky until reset or flush.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (CLR_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (PUSH_i & full_q) ovf_q <= 1'b1;
      if (POP_i & empty_q) unf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// Directed bench for bram_sdp_fifo_ctrl at ADDR_WIDTH=4 with a behavioural BRAM.
module tb_bram_sdp_fifo_ctrl;
  localparam int DW = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, clr, push, pop;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid, full, empty, afull, aempty;
  logic [AW:0]   count;
  logic [AW-1:0] bwaddr, braddr;
  logic [DW-1:0] bwdata;
  logic          bwen, bren;
  logic [1:0]    bbe;
  logic [DW-1:0] brdata;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  logic          ovf, unf;
`endif

  bram_sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut (
    .CLK_i(clk), .RST_i(rst), .CLR_i(clr), .PUSH_i(push), .WDATA_i(wdata), .POP_i(pop),
    .RDATA_o(rdata), .RVALID_o(rvalid), .FULL_o(full), .EMPTY_o(empty),
    .ALMOST_FULL_o(afull), .ALMOST_EMPTY_o(aempty), .COUNT_o(count),
    .BRAM_WADDR_o(bwaddr), .BRAM_WDATA_o(bwdata), .BRAM_WEN_o(bwen), .BRAM_BE_o(bbe),
    .BRAM_RADDR_o(braddr), .BRAM_REN_o(bren), .BRAM_RDATA_i(brdata)
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    , .OVERFLOW_o(ovf), .UNDERFLOW_o(unf)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (bwen) mem[bwaddr] <= bwdata;
    if (bren) brdata <= mem[braddr];
  end

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    #12;
    @(negedge clk); rst = 1'b0;
    tick();
    checks++; if (count !== 5'd0)  begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty act=%b exp=1", empty); end
    checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty act=%b exp=1", aempty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full act=%b exp=0", full); end
    checks++; if (afull !== 1'b0)  begin errors++; $display("FAIL reset_afull act=%b exp=0", afull); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid act=%b exp=0", rvalid); end
    checks++; if (bwen !== 1'b0 || bren !== 1'b0) begin errors++; $display("FAIL reset_strobes wen=%b ren=%b exp=0", bwen, bren); end
    $display("reset done t=%0t", $time);
  endtask

  task automatic test_basic();
    logic [DW-1:0] v [3];
    v[0] = 18'h00011; v[1] = 18'h00022; v[2] = 18'h00033;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; wdata = v[i];
      #1;
      checks++; if (bwaddr !== AW'(i)) begin errors++; $display("FAIL basic_waddr act=%0d exp=%0d", bwaddr, i); end
      checks++; if (bwen !== 1'b1 || bbe !== 2'b11) begin errors++; $display("FAIL basic_wen act=%b be=%b exp=1/11", bwen, bbe); end
      checks++; if (bwdata !== v[i]) begin errors++; $display("FAIL basic_wdata act=%h exp=%h", bwdata, v[i]); end
      tick();
      $display("push addr=%0d data=%h", i, v[i]);
    end
    push = 1'b0;
    #1;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count3 act=%0d exp=3", count); end
    checks++; if (empty !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL basic_flags3 empty=%b aempty=%b exp=0/1", empty, aempty); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (braddr !== AW'(i) || bren !== 1'b1) begin errors++; $display("FAIL basic_raddr act=%0d ren=%b exp=%0d/1", braddr, bren, i); end
      tick();
      checks++; if (rvalid !== 1'b1 || rdata !== v[i]) begin errors++; $display("FAIL basic_rdata act=%h v=%b exp=%h", rdata, rvalid, v[i]); end
      $display("pop addr=%0d data=%h", i, rdata);
    end
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL basic_end empty=%b count=%0d exp=1/0", empty, count); end
    #1;
    checks++; if (bren !== 1'b0) begin errors++; $display("FAIL basic_pop_empty_ren act=%b exp=0", bren); end
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_pop_empty_rvalid act=%b exp=0", rvalid); end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL basic_underflow act=%b exp=1", unf); end
`endif
    pop = 1'b0;
  endtask

  task automatic test_full();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; wdata = 18'h100 + DW'(i);
      #1;
      checks++; if (bwaddr !== AW'(3 + i) || bwen !== 1'b1) begin errors++; $display("FAIL full_waddr act=%0d wen=%b exp=%0d/1", bwaddr, bwen, (3 + i) % 16); end
      tick();
      q.push_back(wdata);
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL full_count act=%0d exp=%0d", count, i + 1); end
      checks++; if (afull !== (i + 1 >= 12)) begin errors++; $display("FAIL full_afull act=%b exp=%b at count %0d", afull, (i + 1 >= 12), i + 1); end
      checks++; if (aempty !== (i + 1 <= 4)) begin errors++; $display("FAIL full_aempty act=%b exp=%b at count %0d", aempty, (i + 1 <= 4), i + 1); end
      checks++; if (full !== (i == 15)) begin errors++; $display("FAIL full_flag act=%b exp=%b at count %0d", full, (i == 15), i + 1); end
    end
    wdata = 18'h3FFFF;
    #1;
    checks++; if (bwen !== 1'b0) begin errors++; $display("FAIL full_push17_wen act=%b exp=0", bwen); end
    tick();
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_push17_count act=%0d full=%b exp=16/1", count, full); end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_overflow act=%b exp=1", ovf); end
`endif
    push = 1'b0;
  endtask

  task automatic test_full_push_pop();
    push = 1'b1; pop = 1'b1; wdata = 18'h2AAAA;
    #1;
    checks++; if (bwen !== 1'b0 || bren !== 1'b1) begin errors++; $display("FAIL fpp_strobes wen=%b ren=%b exp=0/1", bwen, bren); end
    checks++; if (braddr !== 4'd3) begin errors++; $display("FAIL fpp_raddr act=%0d exp=3", braddr); end
    tick();
    exp_d = q.pop_front();
    checks++; if (count !== 5'd15 || full !== 1'b0) begin errors++; $display("FAIL fpp_count act=%0d full=%b exp=15/0", count, full); end
    checks++; if (rvalid !== 1'b1 || rdata !== exp_d) begin errors++; $display("FAIL fpp_rdata act=%h v=%b exp=%h", rdata, rvalid, exp_d); end
    $display("pop-on-full data=%h", rdata);
    push = 1'b0;
  endtask

  task automatic test_wrap();
    pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_d = q.pop_front();
      checks++; if (rvalid !== 1'b1 || rdata !== exp_d) begin errors++; $display("FAIL drain_rdata act=%h v=%b exp=%h", rdata, rvalid, exp_d); end
      checks++; if (count !== 5'(14 - i)) begin errors++; $display("FAIL drain_count act=%0d exp=%0d", count, 14 - i); end
    end
    push = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 18'h1000 + DW'(i);
      tick();
      q.push_back(wdata);
      exp_d = q.pop_front();
      checks++; if (rvalid !== 1'b1 || rdata !== exp_d) begin errors++; $display("FAIL wrap_rdata i=%0d act=%h v=%b exp=%h", i, rdata, rvalid, exp_d); end
      checks++; if (count !== 5'd5 || aempty !== 1'b0 || afull !== 1'b0) begin errors++; $display("FAIL wrap_state count=%0d ae=%b af=%b exp=5/0/0", count, aempty, afull); end
      $display("pair %0d pop data=%h", i, rdata);
    end
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_clear();
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 18'h2000 + DW'(i);
      tick();
      q.push_back(wdata);
    end
    push = 1'b0; pop = 1'b1;
    tick();
    exp_d = q.pop_front();
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL clr_pre_count act=%0d exp=7", count); end
    clr = 1'b1; push = 1'b1;
    #1;
    checks++; if (bren !== 1'b0 || bwen !== 1'b0) begin errors++; $display("FAIL clr_strobes ren=%b wen=%b exp=0/0", bren, bwen); end
    checks++; if (rvalid !== 1'b1 || rdata !== exp_d) begin errors++; $display("FAIL clr_inflight act=%h v=%b exp=%h", rdata, rvalid, exp_d); end
    tick();
    clr = 1'b0; push = 1'b0; pop = 1'b0;
    q.delete();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1) begin errors++; $display("FAIL clr_after count=%0d empty=%b ae=%b exp=0/1/1", count, empty, aempty); end
    checks++; if (full !== 1'b0 || afull !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL clr_after2 full=%b af=%b v=%b exp=0/0/0", full, afull, rvalid); end
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL clr_errflags ovf=%b unf=%b exp=0/0", ovf, unf); end
`endif
    push = 1'b1; wdata = 18'h0ABCD;
    #1;
    checks++; if (bwaddr !== 4'd0 || bwen !== 1'b1 || braddr !== 4'd0) begin errors++; $display("FAIL clr_waddr act=%0d wen=%b raddr=%0d exp=0/1/0", bwaddr, bwen, braddr); end
    tick();
    push = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL clr_push_count act=%0d exp=1", count); end
    $display("push after clear addr=0 data=%h", wdata);
  endtask

  task automatic test_async_reset();
    push = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wdata = 18'h3000 + DW'(i);
      tick();
    end
    push = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL arst_pre_count act=%0d exp=3", count); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 18'h0ABCD) begin errors++; $display("FAIL arst_pre_rdata act=%h v=%b exp=0abcd", rdata, rvalid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rvalid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL arst_immediate v=%b count=%0d exp=0/0", rvalid, count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty act=%b exp=1", empty); end
    @(negedge clk); rst = 1'b0;
    tick();
    push = 1'b1; wdata = 18'h00001;
    #1;
    checks++; if (bwaddr !== 4'd0 || braddr !== 4'd0) begin errors++; $display("FAIL arst_ptrs waddr=%0d raddr=%0d exp=0/0", bwaddr, braddr); end
    tick();
    push = 1'b0;
    $display("async reset done t=%0t", $time);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
